// File: rtl/universal_shift_reg_param_if.sv
// Command/data bundle for the universal shift register.
// master drives commands and serial fills; slave is the register itself.
interface universal_shift_reg_param_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = $clog2(WIDTH) + 1
);
    logic             start;
    logic [2:0]       op;
    logic [AW-1:0]    amt;
    logic [WIDTH-1:0] Data_In;
    logic             MSB_In;
    logic             LSB_In;
    logic [WIDTH-1:0] Data_Out;
    logic             MSB_Out;
    logic             LSB_Out;
    logic             busy;
    logic             done;

    modport master (
        output start, op, amt, Data_In, MSB_In, LSB_In,
        input  Data_Out, MSB_Out, LSB_Out, busy, done
    );

    modport slave (
        input  start, op, amt, Data_In, MSB_In, LSB_In,
        output Data_Out, MSB_Out, LSB_Out, busy, done
    );
endinterface

// File: rtl/universal_shift_reg_param.sv
// Universal shift register: load/clear/hold in one cycle, shift and rotate ops
// applied one bit per clock for a saturated count of steps.
module universal_shift_reg_param #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = $clog2(WIDTH) + 1
) (
    input logic                          clk,
    input logic                          rst,
    universal_shift_reg_param_if.slave   bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             done_q, done_d;
    logic [CW-1:0]    n_eff;

    function automatic logic [WIDTH-1:0] step(input logic [2:0]       o,
                                              input logic [WIDTH-1:0] d,
                                              input logic             msb,
                                              input logic             lsb);
        case (o)
            3'd1:    return {msb, d[WIDTH-1:1]};
            3'd2:    return {d[WIDTH-2:0], lsb};
            3'd4:    return {d[0], d[WIDTH-1:1]};
            3'd5:    return {d[WIDTH-2:0], d[WIDTH-1]};
            3'd6:    return {d[WIDTH-1], d[WIDTH-1:1]};
            default: return d;
        endcase
    endfunction

    // Counts beyond the register width saturate to WIDTH.
    always_comb begin
        if (32'(bus.amt) > WIDTH) begin
            n_eff = CW'(WIDTH);
        end else begin
            n_eff = CW'(bus.amt);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    op_d = bus.op;
                    case (bus.op)
                        3'd0: done_d = 1'b1;
                        3'd3: begin
                            data_d = bus.Data_In;
                            done_d = 1'b1;
                        end
                        3'd7: begin
                            data_d = '0;
                            done_d = 1'b1;
                        end
                        default: begin
                            // First step lands on the accepting edge itself.
                            if (n_eff == '0) begin
                                done_d = 1'b1;
                            end else begin
                                data_d = step(bus.op, data_q, bus.MSB_In, bus.LSB_In);
                                if (n_eff == CW'(1)) begin
                                    done_d = 1'b1;
                                end else begin
                                    state_d = StShift;
                                    cnt_d   = n_eff - CW'(1);
                                end
                            end
                        end
                    endcase
                end
            end
            StShift: begin
                data_d = step(op_q, data_q, bus.MSB_In, bus.LSB_In);
                if (cnt_q <= CW'(1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= 3'd0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign bus.Data_Out = data_q;
    assign bus.MSB_Out  = data_q[WIDTH-1];
    assign bus.LSB_Out  = data_q[0];
    assign bus.busy     = (state_q == StShift);
    assign bus.done     = done_q;
endmodule

// File: doc/universal_shift_reg_param.md
UNIVERSAL_SHIFT_REG_PARAM -- requirements
Module: universal_shift_reg_param

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits; legal range 2 to 64.
REQ-002 Parameter AW, default $clog2(WIDTH)+1: width of the shift-amount port.
REQ-003 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: command strobe; sampled only in IDLE.
REQ-006 Port op, input, 3: command opcode, sampled with start.
- Encoding: 0 hold, 1 shift right, 2 shift left, 3 parallel load, 4 rotate right, 5 rotate left, 6 arithmetic shift right, 7 clear.
REQ-007 Port amt, input, AW: shift count for ops 1, 2, 4, 5, 6; sampled with start.
REQ-008 Port Data_In, input, WIDTH: parallel load value for op 3.
REQ-009 Port MSB_In, input, 1: serial fill bit for shift right; sampled on every shift edge.
REQ-010 Port LSB_In, input, 1: serial fill bit for shift left; sampled on every shift edge.
REQ-011 Port Data_Out, output, WIDTH: register contents.
REQ-012 Port MSB_Out, output, 1: Data_Out[WIDTH-1], combinational.
REQ-013 Port LSB_Out, output, 1: Data_Out[0], combinational.
REQ-014 Port busy, output, 1: high while a multi-cycle shift is in progress.
REQ-015 Port done, output, 1: one-cycle pulse on completion of any accepted command.

Function
REQ-016 The FSM SHALL have two states, IDLE and SHIFT; busy SHALL be 1 exactly when in SHIFT.
REQ-017 start=1 in IDLE SHALL accept op/amt on that edge; start in SHIFT SHALL be ignored, with no queuing.
REQ-018 Single-step behaviour of each op, applied once per shift edge:
- shift right: {MSB_In, Data_Out[WIDTH-1:1]}
- shift left: {Data_Out[WIDTH-2:0], LSB_In}
- rotate right: {Data_Out[0], Data_Out[WIDTH-1:1]}
- rotate left: {Data_Out[WIDTH-2:0], Data_Out[WIDTH-1]}
- arithmetic shift right: {Data_Out[WIDTH-1], Data_Out[WIDTH-1:1]}
REQ-019 For shift-class ops, an effective count N = min(amt, WIDTH) SHALL apply; amt > WIDTH SHALL saturate to WIDTH.
REQ-020 N SHALL be applied as one bit per edge; the first step SHALL occur on the accepting edge t, and step k on edge t+k-1.
REQ-021 After step N the FSM SHALL be in IDLE with done=1 for exactly one cycle.
- N=1: no SHIFT state entered; done high in the cycle after edge t.
- N>1: SHIFT entered after edge t and left after edge t+N-1; busy high for N-1 cycles.
REQ-022 A remaining-step counter SHALL decrement on each step; the FSM SHALL leave SHIFT when it reaches 0, with no wrap-around.
REQ-023 Shift-class ops with N=0 SHALL leave Data_Out unchanged and pulse done after edge t.
REQ-024 Ops 0, 3 and 7 SHALL complete on edge t, with done pulsed after edge t and no SHIFT state entered.
- op 0: hold.
- op 3: Data_Out <= Data_In.
- op 7: Data_Out <= 0.
REQ-025 In IDLE without an accepted start, Data_Out SHALL hold and done SHALL be 0.
REQ-026 done and busy SHALL never be high in the same cycle.
REQ-027 A new start in the cycle where done=1 SHALL be accepted, giving back-to-back commands with no gap.

Reset
REQ-028 rst=0 SHALL immediately, without waiting for a clock edge, force:
- Data_Out=0, busy=0, done=0
- state=IDLE, remaining-step counter=0
REQ-029 Reset asserted mid-SHIFT SHALL abort the command with no done pulse; start SHALL be ignored while rst=0.
REQ-030 The first accepted command SHALL be on the first rising edge with rst=1 and start=1.

Verification (WIDTH=8)
REQ-031 Load and shift right: load 0xA5, then op=1, amt=3, MSB_In=1 -> Data_Out D2, E9, F4 on successive edges; busy high 2 cycles; done pulses once; final Data_Out=0xF4.
REQ-032 Full rotation: load 0x81, then op=5, amt=8 -> Data_Out=0x81 after 8 edges; busy high 7 cycles.
REQ-033 Arithmetic shift: load 0x90, then op=6, amt=2 -> Data_Out=0xE4.
REQ-034 Saturation and shift left: load 0x0F, then op=2, amt=15, LSB_In=0 -> 8 steps, Data_Out=0x00. Repeat with amt=4 -> Data_Out=0xF0, MSB_Out=1, LSB_Out=0.
REQ-035 Boundary commands: start during busy -> ignored, Data_Out unaffected. op=1 with amt=0 -> Data_Out unchanged, done one cycle after edge t, busy never high.
REQ-036 Reset mid-shift: rst=0 during cycle 3 of a 6-step shift -> Data_Out=0 and busy=0 asynchronously, no done pulse. After release, load 0x3C -> Data_Out=0x3C.
